instruction_cache: RTL and testbench
====================================

# instruction_cache

Direct-mapped, read-only instruction cache between the CPU's program counter and the instruction memory. It returns the 32-bit instruction for `PC` in the same cycle on a hit. On a miss it raises `BUSYWAIT`, which stalls the CPU, and fetches the whole 16-byte block from instruction memory over a request/busywait handshake. Capacity is 8 blocks × 4 words, covering a 1 KiB instruction space (`PC[9:0]`).

## Interface
- `BLOCKS`, 8: number of cache lines (index width 3).
- `WORDS_PER_BLOCK`, 4: 32-bit words per line (offset width 2).
- `ADDR_BITS`, 10: significant PC bits; tag width = 10 − 3 − 2 − 2 = 3.
- One clock; reset is asynchronous and active-high (`CLK`, `RESET`).
- `CLK` input 1: system clock; all state changes on the rising edge.
- `RESET` input 1: asynchronous, active-high; clears all valid bits and the FSM.
- `PC` input 32: fetch address; bits [1:0] and [31:10] are ignored.
- `INSTRUCTION` output 32: instruction word for `PC`; valid only while `BUSYWAIT` = 0.
- `BUSYWAIT` output 1: high means the CPU must hold `PC` and suppress register/PC writes.
- `MEM_READ` output 1: block read request to instruction memory.
- `MEM_ADDRESS` output 6: block address `{tag, index}` = `PC[9:4]` of the missing block.
- `MEM_READDATA` input 128: fetched block; word w is in bits [32w+31:32w].
- `MEM_BUSYWAIT` input 1: memory is busy; data is valid in the cycle it falls with `MEM_READ` high.

## Operation
- Address split:
  - offset = `PC[3:2]`
  - index = `PC[6:4]`
  - tag = `PC[9:7]`
- Per line storage: valid bit, 3-bit tag, 128-bit data.
- Hit = valid[index] && tag[index] == tag. Evaluated combinationally.
- `INSTRUCTION` = data[index] word[offset]. It is driven even on a miss, but its value is don't-care then.
- FSM states: IDLE, READ_MEM, UPDATE.
  - IDLE, hit: `BUSYWAIT` = 0. Stay in IDLE.
  - IDLE, miss: `BUSYWAIT` = 1 combinationally in the same cycle. Latch `PC[9:4]` into the miss-address register. Go to READ_MEM.
  - READ_MEM: `MEM_READ` = 1, `MEM_ADDRESS` = latched address, `BUSYWAIT` = 1.
    - Stay while `MEM_BUSYWAIT` = 1.
    - When `MEM_BUSYWAIT` = 0 at a rising edge, capture `MEM_READDATA` into the fill buffer and go to UPDATE.
  - UPDATE: `MEM_READ` = 0, `BUSYWAIT` = 1. At the edge, write the fill buffer, latched tag and valid = 1 into the latched index. Go to IDLE.
- The fill uses the latched address, not the live `PC`. A `PC` change during a miss (CPU protocol violation) cannot corrupt a line.
- The new line replaces the old one unconditionally. Lines are never dirty.
- No artificial `#` delays inside this block.

## Timing
- Reset values:
  - state = IDLE; all valid = 0; miss-address register = 0.
  - `MEM_READ` = 0, `MEM_ADDRESS` = 0.
  - `BUSYWAIT` = 0 while `RESET` is high.
  - `INSTRUCTION` is don't-care during reset (data array is not cleared).
- Hit latency: 0 cycles (combinational `PC` → `INSTRUCTION`).
- Miss stall = 1 (IDLE) + M (READ_MEM cycles, M ≥ 1) + 1 (UPDATE). The hit is served in the following IDLE cycle.
  - Example: memory holding `MEM_BUSYWAIT` high for 5 READ_MEM cycles gives M = 6 and a stall of 8 cycles.
- `MEM_READ` goes high on the edge entering READ_MEM and low on the edge entering UPDATE. It is never high in IDLE.
- `RESET` asserted mid-miss:
  - FSM goes to IDLE and `MEM_READ` drops immediately (asynchronous).
  - No line is written; all lines are invalidated.
- First fetch after reset always misses.
- Back-to-back misses to different blocks each take the full miss sequence. There is no prefetch.
- The wrap from `PC` = 0x3FC to 0x400 aliases to index 0, tag 0 (bits above 9 are ignored).

## Structure
- Package `icache_pkg` holds:
  - FSM state enum (IDLE, READ_MEM, UPDATE);
  - `TAG_W`, `INDEX_W`, `OFFSET_W`, `BLOCK_W` = 128;
  - the address-field slice constants.
- One sub-module, `icache_line_array`: the valid/tag/data storage with an asynchronous clear of valid bits, one combinational read port and one clocked write port.
- The top level holds the FSM, the miss-address register, the fill buffer and the output muxing.

## Test plan
- Cold miss:
  - Stimulus: release `RESET`, `PC` = 0x000; memory returns block {0x44,0x33,0x22,0x11} (word3..word0) after 3 busy cycles.
  - Required: `BUSYWAIT` high for 6 cycles, `MEM_ADDRESS` = 0x00, then `INSTRUCTION` = 0x11 with `BUSYWAIT` = 0.
- Hit reuse: after the cold fill, step `PC` through 0x004, 0x008, 0x00C.
  - Required: `BUSYWAIT` stays 0, `INSTRUCTION` = 0x22, 0x33, 0x44 in the same cycles, `MEM_READ` never asserted.
- Conflict eviction:
  - Stimulus: fill `PC` = 0x010, then `PC` = 0x090 (same index 1, tag 1), then 0x010 again.
  - Required: three misses with `MEM_ADDRESS` = 0x01, 0x09, 0x01; the final data is the 0x010 block.
- Reset mid-miss:
  - Stimulus: assert `RESET` during READ_MEM, hold it 1 cycle, then refetch a previously valid `PC`.
  - Required: `MEM_READ` = 0 immediately, and the refetch misses (valid cleared).
- `PC` change during stall:
  - Stimulus: miss on 0x020, then move `PC` to 0x100 mid-READ_MEM.
  - Required: line index 2 is tagged 0 with the 0x020 data; 0x100 then takes its own miss.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped
// instruction cache.
package icache_pkg;

    localparam int BLOCKS          = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int ADDR_BITS       = 10;

    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 3;
    localparam int TAG_W    = 3;
    localparam int BLOCK_W  = 128;
    localparam int BADDR_W  = TAG_W + INDEX_W;

    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int TAG_LSB    = 7;

    typedef enum logic [1:0] {
        IDLE,
        READ_MEM,
        UPDATE
    } state_t;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [BLOCK_W-1:0] block_t;

    function automatic logic [WORD_W-1:0] word_sel(
        input block_t                blk,
        input logic [OFFSET_W-1:0]   off
    );
        return blk[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Block-read bus between the instruction cache (master) and
// instruction memory (slave).
interface instruction_cache_if;
    import icache_pkg::*;

    logic               MEM_READ;
    logic [BADDR_W-1:0] MEM_ADDRESS;
    block_t             MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport master (
        output MEM_READ,
        output MEM_ADDRESS,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ,
        input  MEM_ADDRESS,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one clocked
// write port, valid bits cleared asynchronously.
module icache_line_array
    import icache_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output block_t rd_data,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  block_t wr_data
);

    logic [BLOCKS-1:0] valid;
    tag_t              tags  [BLOCKS];
    block_t            lines [BLOCKS];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is ignored until its valid bit is set.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, whole
// 16-byte block refill on a miss.
module instruction_cache
    import icache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         PC,
    output logic [WORD_W-1:0]   INSTRUCTION,
    output logic                BUSYWAIT,
    instruction_cache_if.master mem
);

    state_t             state;
    logic [BADDR_W-1:0] miss_addr;
    block_t             fill_buf;
    logic               mem_read_q;

    logic                rd_valid;
    tag_t                rd_tag;
    block_t              rd_data;
    logic                hit;
    logic                wr_en;
    index_t              pc_index;
    tag_t                pc_tag;
    logic [OFFSET_W-1:0] pc_offset;
    logic                unused_pc;

    assign pc_offset = PC[OFFSET_LSB +: OFFSET_W];
    assign pc_index  = PC[INDEX_LSB +: INDEX_W];
    assign pc_tag    = PC[TAG_LSB +: TAG_W];
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[OFFSET_LSB-1:0]};

    icache_line_array u_lines (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (miss_addr[INDEX_W-1:0]),
        .wr_tag   (miss_addr[BADDR_W-1:INDEX_W]),
        .wr_data  (fill_buf)
    );

    assign hit   = rd_valid && (rd_tag == pc_tag);
    assign wr_en = (state == UPDATE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            miss_addr  <= '0;
            fill_buf   <= '0;
            mem_read_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_addr  <= PC[INDEX_LSB +: BADDR_W];
                        mem_read_q <= 1'b1;
                        state      <= READ_MEM;
                    end
                end
                READ_MEM: begin
                    if (!mem.MEM_BUSYWAIT) begin
                        fill_buf   <= mem.MEM_READDATA;
                        mem_read_q <= 1'b0;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Stall is raised in the very cycle a miss is seen, not a cycle later.
    assign BUSYWAIT    = !RESET && ((state != IDLE) || !hit);
    assign INSTRUCTION = word_sel(rd_data, pc_offset);

    assign mem.MEM_READ    = mem_read_q;
    assign mem.MEM_ADDRESS = miss_addr;

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache against a
// behavioural line-presence model and a word-addressed memory image.
module tb_instruction_cache;
    import icache_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] PC = 32'h0;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;

    instruction_cache_if mem_if ();

    instruction_cache dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION),
        .BUSYWAIT    (BUSYWAIT),
        .mem         (mem_if)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_words [256];
    bit          ref_valid [8];
    logic [2:0]  ref_tag   [8];
    int          busy_n = 0;

    function automatic logic [127:0] blk(input logic [5:0] a);
        return {mem_words[{a, 2'd3}], mem_words[{a, 2'd2}],
                mem_words[{a, 2'd1}], mem_words[{a, 2'd0}]};
    endfunction

    function automatic bit ref_hit(input logic [31:0] pc);
        return ref_valid[pc[6:4]] && (ref_tag[pc[6:4]] == pc[9:7]);
    endfunction

    function automatic void ref_fill(input logic [31:0] pc);
        ref_valid[pc[6:4]] = 1'b1;
        ref_tag[pc[6:4]]   = pc[9:7];
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endfunction

    // Memory: busy for busy_n cycles of an active read, then data.
    initial begin
        int cnt;
        cnt = 0;
        mem_if.MEM_BUSYWAIT = 1'b0;
        mem_if.MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (mem_if.MEM_READ) begin
                if (cnt < busy_n) begin
                    mem_if.MEM_BUSYWAIT = 1'b1;
                    mem_if.MEM_READDATA = {$urandom, $urandom,
                                           $urandom, $urandom};
                    cnt++;
                end else begin
                    mem_if.MEM_BUSYWAIT = 1'b0;
                    mem_if.MEM_READDATA = blk(mem_if.MEM_ADDRESS);
                end
            end else begin
                cnt = 0;
                mem_if.MEM_BUSYWAIT = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input int bn);
        bit   exp_hit;
        int   exp_stall;
        int   stall;
        int   rd_cycles;
        bit   done;
        logic [5:0] addr_seen;
        exp_hit   = ref_hit(pc);
        exp_stall = exp_hit ? 0 : bn + 3;
        stall     = 0;
        rd_cycles = 0;
        done      = 1'b0;
        addr_seen = '0;
        @(posedge CLK);
        #1;
        busy_n = bn;
        RESET  = 1'b0;
        PC     = pc;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
            stall++;
            if (mem_if.MEM_READ) begin
                rd_cycles++;
                addr_seen = mem_if.MEM_ADDRESS;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL fetch_timeout pc=%h busywait stuck high", pc);
            return;
        end
        vectors++;
        if (stall !== exp_stall) begin
            miscompares++;
            $display("FAIL stall pc=%h got %0d want %0d",
                     pc, stall, exp_stall);
        end
        vectors++;
        if (INSTRUCTION !== mem_words[pc[9:2]]) begin
            miscompares++;
            $display("FAIL instr pc=%h got %h want %h",
                     pc, INSTRUCTION, mem_words[pc[9:2]]);
        end
        vectors++;
        if (mem_if.MEM_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_read_idle pc=%h got %b want 0",
                     pc, mem_if.MEM_READ);
        end
        if (!exp_hit) begin
            vectors++;
            if (rd_cycles !== bn + 1) begin
                miscompares++;
                $display("FAIL read_cycles pc=%h got %0d want %0d",
                         pc, rd_cycles, bn + 1);
            end
            vectors++;
            if (addr_seen !== pc[9:4]) begin
                miscompares++;
                $display("FAIL mem_addr pc=%h got %h want %h",
                         pc, addr_seen, pc[9:4]);
            end
        end
        ref_fill(pc);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        PC    = 32'h0;
        ref_clear();
        repeat (2) @(negedge CLK);
        vectors++;
        if (BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busywait got %b want 0", BUSYWAIT);
        end
        vectors++;
        if (mem_if.MEM_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_read got %b want 0", mem_if.MEM_READ);
        end
        vectors++;
        if (mem_if.MEM_ADDRESS !== 6'h00) begin
            miscompares++;
            $display("FAIL reset_mem_addr got %h want 00",
                     mem_if.MEM_ADDRESS);
        end
    endtask

    task automatic test_cold_miss();
        mem_words[0] = 32'h11;
        mem_words[1] = 32'h22;
        mem_words[2] = 32'h33;
        mem_words[3] = 32'h44;
        fetch(32'h000, 3);
    endtask

    task automatic test_hit_reuse();
        fetch(32'h004, 0);
        fetch(32'h008, 0);
        fetch(32'h00C, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h010, $urandom_range(0, 4));
        fetch(32'h090, $urandom_range(0, 4));
        fetch(32'h010, $urandom_range(0, 4));
    endtask

    task automatic test_reset_mid_miss();
        @(posedge CLK);
        #1;
        busy_n = 5;
        PC     = 32'h030;
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (mem_if.MEM_READ !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_miss_read got %b want 1", mem_if.MEM_READ);
        end
        #2;
        RESET = 1'b1;
        #1;
        vectors++;
        if (mem_if.MEM_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL async_drop got %b want 0", mem_if.MEM_READ);
        end
        vectors++;
        if (BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", BUSYWAIT);
        end
        ref_clear();
        @(negedge CLK);
        fetch(32'h000, 2);
    endtask

    task automatic test_pc_change();
        int         stall;
        bit         done;
        bit         prev_rd;
        logic [5:0] addrs [$];
        stall   = 0;
        done    = 1'b0;
        prev_rd = 1'b0;
        @(posedge CLK);
        #1;
        busy_n = 4;
        PC     = 32'h020;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
            stall++;
            if (mem_if.MEM_READ && !prev_rd) addrs.push_back(mem_if.MEM_ADDRESS);
            prev_rd = mem_if.MEM_READ;
            if (i == 1) begin
                @(posedge CLK);
                #1;
                PC = 32'h100;
            end
        end
        vectors++;
        if (!done || stall !== 14) begin
            miscompares++;
            $display("FAIL pc_change_stall got %0d want 14", stall);
        end
        vectors++;
        if (addrs.size() !== 2 || addrs[0] !== 6'h02 || addrs[1] !== 6'h10) begin
            miscompares++;
            $display("FAIL pc_change_addrs got n=%0d want 02,10", addrs.size());
        end
        vectors++;
        if (INSTRUCTION !== mem_words[8'h40]) begin
            miscompares++;
            $display("FAIL pc_change_instr got %h want %h",
                     INSTRUCTION, mem_words[8'h40]);
        end
        ref_fill(32'h020);
        ref_fill(32'h100);
        fetch(32'h020, 1);
        fetch(32'h024, 1);
    endtask

    task automatic test_wrap();
        fetch(32'h3FC, 1);
        fetch(32'h400, 1);
        fetch(32'h000, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            fetch($urandom, $urandom_range(0, 4));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        test_reset();
        test_cold_miss();
        test_hit_reuse();
        test_conflict();
        test_reset_mid_miss();
        test_pc_change();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
